// File: rtl/cnn_sched_pkg.sv
// Shared types and step decode for the CNN layer step scheduler.
// The step class table and the pointwise pack-length lookup live here.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LD = 3'd2,
    S_WAIT_CV = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  localparam logic [1:0] KIND_PIX  = 2'd0;
  localparam logic [1:0] KIND_DW   = 2'd1;
  localparam logic [1:0] KIND_PW   = 2'd2;
  localparam logic [1:0] KIND_COMP = 2'd3;

  typedef struct packed {
    logic       legal;
    logic [3:0] len;
  } pw_pack_t;

  function automatic logic [1:0] step_kind(input logic [6:0] s);
    logic [1:0] k;
    case (s)
      7'd1, 7'd2:                                       k = KIND_PIX;
      7'd3, 7'd7, 7'd11, 7'd15, 7'd19, 7'd23, 7'd27,
      7'd31, 7'd37, 7'd41, 7'd45, 7'd49:                k = KIND_DW;
      7'd5, 7'd9, 7'd13, 7'd17, 7'd21, 7'd25, 7'd29,
      7'd33, 7'd35, 7'd39, 7'd43, 7'd47, 7'd51:         k = KIND_PW;
      default:                                          k = KIND_COMP;
    endcase
    return k;
  endfunction

  // Only these input-map counts pack evenly into one weight RAM word.
  function automatic pw_pack_t pw_pack(input logic [6:0] i_f);
    pw_pack_t p;
    p.legal = 1'b1;
    case (i_f)
      7'd0:    p.len = 4'd1;
      7'd2:    p.len = 4'd3;
      7'd5:    p.len = 4'd6;
      7'd8:    p.len = 4'd9;
      7'd11:   p.len = 4'd12;
      default: begin
        p.legal = 1'b0;
        p.len   = 4'd0;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/layer_step_scheduler.sv
// Handshaked step sequencer: issues one start per step and waits for the
// matching done pulse, with a saturating timeout that traps into ERR.
module layer_step_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_STEPS = 52,
  parameter int TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] i_f,
  input  logic       ld_done,
  input  logic       cv_done,
  output logic [6:0] step,
  output logic [1:0] kind,
  output logic [3:0] pack_len,
  output logic       ld_start,
  output logic       cv_start,
  output logic       busy,
  output logic       finished,
  output logic       err
);

  localparam logic [6:0]  LAST_STEP = 7'(NUM_STEPS);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next, cnt_inc;
  logic [6:0]  issue_step, step_next;
  logic [1:0]  issue_kind, kind_next;
  logic [3:0]  issue_pack, pack_next;
  logic        issue_ok, take;
  logic        ld_next, cv_next, busy_next, fin_next, err_next;
  state_t      issue_state;
  pw_pack_t    pw;

  // Decode of the step about to be issued (first step or the next one).
  always_comb begin
    issue_step  = (state == S_ADVANCE) ? (step + 7'd1) : 7'd1;
    issue_kind  = step_kind(issue_step);
    pw          = pw_pack(i_f);
    issue_ok    = (issue_kind != KIND_PW) || pw.legal;
    issue_pack  = (issue_kind == KIND_DW) ? 4'd9 :
                  ((issue_kind == KIND_PW) && pw.legal) ? pw.len : 4'd0;
    issue_state = issue_ok ? S_ISSUE : S_ERR;
    cnt_inc     = (cnt == 16'hFFFF) ? cnt : (cnt + 16'd1);
  end

  // Next-state and next-output logic; all outputs are registered from here.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    take       = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        take       = go;
        state_next = go ? issue_state : state;
      end
      S_ISSUE: begin
        cnt_next   = 16'd0;
        state_next = (kind == KIND_COMP) ? S_WAIT_CV : S_WAIT_LD;
      end
      S_WAIT_LD: begin
        cnt_next   = cnt_inc;
        state_next = ld_done ? S_ADVANCE : ((cnt_inc == TO_LIMIT) ? S_ERR : S_WAIT_LD);
      end
      S_WAIT_CV: begin
        cnt_next   = cnt_inc;
        state_next = cv_done ? S_ADVANCE : ((cnt_inc == TO_LIMIT) ? S_ERR : S_WAIT_CV);
      end
      S_ADVANCE: begin
        take       = (step != LAST_STEP);
        state_next = (step == LAST_STEP) ? S_FINISH : issue_state;
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
    step_next = take ? issue_step : step;
    kind_next = take ? issue_kind : kind;
    pack_next = take ? issue_pack : pack_len;
    ld_next   = take && issue_ok && (issue_kind != KIND_COMP);
    cv_next   = take && issue_ok && (issue_kind == KIND_COMP);
    busy_next = (state_next == S_ISSUE) || (state_next == S_WAIT_LD) ||
                (state_next == S_WAIT_CV) || (state_next == S_ADVANCE);
    fin_next  = (state_next == S_FINISH);
    err_next  = (state_next == S_ERR);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 16'd0;
      step     <= 7'd0;
      kind     <= 2'd0;
      pack_len <= 4'd0;
      ld_start <= 1'b0;
      cv_start <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      step     <= step_next;
      kind     <= kind_next;
      pack_len <= pack_next;
      ld_start <= ld_next;
      cv_start <= cv_next;
      busy     <= busy_next;
      finished <= fin_next;
      err      <= err_next;
    end
  end

endmodule

// File: tb/tb_layer_step_scheduler.sv
// Directed self-checking bench for layer_step_scheduler (TIMEOUT shortened to 16).
module tb_layer_step_scheduler;

  logic       clk = 1'b0;
  logic       rst, go;
  logic [6:0] i_f;
  logic       ld_done, cv_done;
  logic [6:0] step;
  logic [1:0] kind;
  logic [3:0] pack_len;
  logic       ld_start, cv_start, busy, finished, err;

  logic model_ld = 1'b0, model_cv = 1'b0;
  logic inj_ld = 1'b0, inj_cv = 1'b0;
  bit   auto_ld = 1'b1, auto_cv = 1'b1;
  int   ld_cd = 0, cv_cd = 0;
  int   n_checks = 0, n_pass = 0;

  assign ld_done = model_ld | inj_ld;
  assign cv_done = model_cv | inj_cv;

  always #5 clk = ~clk;

  layer_step_scheduler #(.NUM_STEPS(52), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .i_f(i_f), .ld_done(ld_done), .cv_done(cv_done),
    .step(step), .kind(kind), .pack_len(pack_len), .ld_start(ld_start),
    .cv_start(cv_start), .busy(busy), .finished(finished), .err(err)
  );

  // Loader answers 2 cycles after a start, conv engine 4 cycles after.
  always @(negedge clk) begin
    model_ld = 1'b0;
    model_cv = 1'b0;
    if (rst) begin
      ld_cd = 0;
      cv_cd = 0;
    end else begin
      if (ld_cd > 0) begin ld_cd--; if (ld_cd == 0) model_ld = 1'b1; end
      if (cv_cd > 0) begin cv_cd--; if (cv_cd == 0) model_cv = 1'b1; end
      if (ld_start && auto_ld) ld_cd = 2;
      if (cv_start && auto_cv) cv_cd = 4;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Independent restatement of the class table: before step 34 DW is 4k+3 and
  // PW is 4k+1; from 34 on the roles swap.
  function automatic int bench_kind(input int s);
    if (s <= 2) return 0;
    if (s <= 33) return (s % 4 == 3) ? 1 : ((s % 4 == 1) ? 2 : 3);
    return (s % 4 == 1) ? 1 : ((s % 4 == 3) ? 2 : 3);
  endfunction

  function automatic int bench_pack(input int s, input int f);
    int k;
    k = bench_kind(s);
    return (k == 1) ? 9 : ((k == 2) ? f + 1 : 0);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq({tag, "_outs"}, 32'({step, kind, pack_len, ld_start, cv_start, busy, finished, err}), 32'd0);
  endtask

  initial begin
    int cyc, last, exp_step, n_ld, n_cv, k4;
    bit prev_comp, seen5;
    rst = 1'b1; go = 1'b0; i_f = 7'd2;
    tick();
    do_reset("reset");

    // Full run with i_f = 2.
    pulse_go();
    check_eq("go_step", 32'(step), 32'd1);
    check_eq("go_busy", 32'(busy), 32'd1);
    check_eq("go_ldstart", 32'(ld_start), 32'd1);
    exp_step = 1; n_ld = 0; n_cv = 0; last = 0; prev_comp = 1'b0;
    for (cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (ld_start || cv_start) begin
        check_eq("run_step", 32'(step), 32'(exp_step));
        check_eq("run_kind", 32'(kind), 32'(bench_kind(exp_step)));
        check_eq("run_pack", 32'(pack_len), 32'(bench_pack(exp_step, 2)));
        check_eq("run_cvsel", 32'(cv_start), 32'(bench_kind(exp_step) == 3));
        if (exp_step > 1) check_eq("run_gap", 32'(cyc - last), prev_comp ? 32'd6 : 32'd4);
        if (ld_start) n_ld++;
        if (cv_start) n_cv++;
        prev_comp = cv_start;
        last = cyc;
        exp_step++;
      end
      tick();
    end
    check_eq("fin_flag", 32'(finished), 32'd1);
    check_eq("fin_busy", 32'(busy), 32'd0);
    check_eq("fin_step", 32'(step), 32'd52);
    check_eq("fin_latency", 32'(cyc - last), 32'd6);
    check_eq("n_ld_start", 32'(n_ld), 32'd27);
    check_eq("n_cv_start", 32'(n_cv), 32'd25);
    check_eq("steps_seen", 32'(exp_step), 32'd53);

    // Restart from FINISH, now with an illegal i_f for the PW step 5.
    i_f = 7'd4;
    pulse_go();
    check_eq("restart_step", 32'(step), 32'd1);
    check_eq("restart_ld", 32'(ld_start), 32'd1);
    check_eq("restart_fin", 32'(finished), 32'd0);
    seen5 = 1'b0; k4 = -100;
    for (cyc = 0; cyc < 200 && !err; cyc++) begin
      if (ld_start && step == 7'd5) seen5 = 1'b1;
      if (cv_start && step == 7'd4) k4 = cyc;
      tick();
    end
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_latency", 32'(cyc - k4), 32'd6);
    check_eq("illegal_no_ld5", 32'(seen5), 32'd0);
    check_eq("illegal_step", 32'(step), 32'd5);
    check_eq("illegal_busy", 32'(busy), 32'd0);
    tick();
    pulse_go();
    tick();
    check_eq("err_hold", 32'({err, ld_start, cv_start}), 32'b100);
    check_eq("err_step_frozen", 32'(step), 32'd5);
    do_reset("reset2");

    // Timeout: conv engine never answers step 4.
    i_f = 7'd2;
    auto_cv = 1'b0;
    pulse_go();
    k4 = -100;
    for (cyc = 0; cyc < 300 && !err; cyc++) begin
      if (cv_start && step == 7'd4) k4 = cyc;
      tick();
    end
    check_eq("timeout_err", 32'(err), 32'd1);
    check_eq("timeout_latency", 32'(cyc - k4 - 1), 32'd16);
    check_eq("timeout_step", 32'(step), 32'd4);
    auto_cv = 1'b1;
    do_reset("reset3");

    // Reset while waiting on the step-3 load.
    pulse_go();
    for (cyc = 0; cyc < 100 && !(ld_start && step == 7'd3); cyc++) tick();
    tick();
    check_eq("wait3_step", 32'(step), 32'd3);
    rst = 1'b1;
    tick();
    check_eq("midrst_outs", 32'({step, kind, pack_len, ld_start, cv_start, busy, finished, err}), 32'd0);
    rst = 1'b0;
    tick();
    auto_ld = 1'b0;
    auto_cv = 1'b0;
    pulse_go();
    check_eq("rst_restart", 32'({step, ld_start, busy}), 32'({7'd1, 1'b1, 1'b1}));

    // Wrong done and go while busy are ignored; done during ISSUE is ignored.
    tick();
    inj_cv = 1'b1; go = 1'b1;
    tick();
    inj_cv = 1'b0; go = 1'b0;
    tick();
    check_eq("ignore_step", 32'(step), 32'd1);
    check_eq("ignore_flags", 32'({busy, ld_start, cv_start, finished, err}), 32'b10000);
    inj_ld = 1'b1;
    tick();
    inj_ld = 1'b0;
    tick();
    check_eq("manual_step2", 32'({step, ld_start, kind}), 32'({7'd2, 1'b1, 2'd0}));
    inj_ld = 1'b1;
    tick();
    inj_ld = 1'b0;
    tick();
    check_eq("issue_done_ignored", 32'({step, ld_start, busy}), 32'({7'd2, 1'b0, 1'b1}));
    inj_ld = 1'b1;
    tick();
    inj_ld = 1'b0;
    tick();
    check_eq("manual_step3", 32'({step, ld_start, kind, pack_len}), 32'({7'd3, 1'b1, 2'd1, 4'd9}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
